// File: rtl/axis_pkt_recorder_if.sv
// AXI4-Stream bundle used for both the recorder's packet input and its record output.
interface axis_pkt_recorder_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) ();
  logic [DATA_WIDTH-1:0] data;
  logic [KEEP_WIDTH-1:0] keep;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport master (output data, keep, last, valid, input ready);
  modport slave  (input data, keep, last, valid, output ready);
endinterface

// File: rtl/axis_pkt_recorder.sv
// Store-and-forward recorder: buffers one AXIS packet, then emits a header flit
// (flit count, last-flit byte count, sequence number) followed by the buffered flits.
module axis_pkt_recorder #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_FLITS  = 64,
  parameter int SEQ_WIDTH  = 32
) (
  input  logic                clk_250mhz,
  input  logic                clk_250mhz_rst,
  axis_pkt_recorder_if.slave  s_axis,
  axis_pkt_recorder_if.master m_axis_rec,
  output logic [63:0]         nr_recorded,
  output logic [31:0]         nr_dropped,
  output logic                busy
);
  localparam int AW = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
  localparam int FW = $clog2(MAX_FLITS) + 1;
  localparam int WW = DATA_WIDTH + KEEP_WIDTH;

  typedef enum logic [2:0] {IDLE, FILL, DROP, HDR, DRAIN} state_t;

  state_t                state, state_next;
  logic [WW-1:0]         mem [MAX_FLITS];
  logic [FW-1:0]         fcnt, fcnt_inc;
  logic [AW-1:0]         rd, rd_idx, wr_idx;
  logic [SEQ_WIDTH-1:0]  seq;
  logic                  ready_r, valid_r, last_r;
  logic [DATA_WIDTH-1:0] data_r, hdr_word;
  logic [KEEP_WIDTH-1:0] keep_r;
  logic [WW-1:0]         rd_word;
  logic                  accept, rec_hs, wr_en, rd_final, rd_idx_last;

  function automatic logic [6:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) n = n + 7'(k[i]);
    return n;
  endfunction

  // NOTE: every signal assigned here gets a value before any branch, so no latch can be inferred.
  always_comb begin
    accept      = s_axis.valid && ready_r;
    rec_hs      = valid_r && m_axis_rec.ready;
    fcnt_inc    = (state == IDLE) ? FW'(1) : fcnt + FW'(1);
    rd_final    = (FW'(rd) == fcnt - FW'(1));
    rd_idx      = (state == HDR) ? '0 : rd + AW'(1);
    rd_idx_last = (FW'(rd_idx) == fcnt - FW'(1));
    wr_en       = accept && (state == IDLE || state == FILL);
    wr_idx      = (state == IDLE) ? '0 : fcnt[AW-1:0];
    state_next  = state;
    case (state)
      IDLE, FILL: if (accept) begin
        if (s_axis.last)                        state_next = HDR;
        else if (fcnt_inc == FW'(MAX_FLITS))    state_next = DROP;
        else                                    state_next = FILL;
      end
      DROP:    if (accept && s_axis.last)  state_next = IDLE;
      HDR:     if (rec_hs)                 state_next = DRAIN;
      DRAIN:   if (rec_hs && rd_final)     state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  always_comb begin
    hdr_word                  = '0;
    hdr_word[15:0]            = 16'(fcnt_inc);
    hdr_word[22:16]           = popcount(s_axis.keep);
    hdr_word[32 +: SEQ_WIDTH] = seq;
  end

  assign rd_word = mem[rd_idx];

  // NOTE: non-blocking assignments keep every register sampling pre-edge values, so process order cannot matter.
  always_ff @(posedge clk_250mhz or posedge clk_250mhz_rst) begin
    if (clk_250mhz_rst) state <= IDLE;
    else                state <= state_next;
  end

  // NOTE: the packet buffer is deliberately not reset; fcnt/rd gate every read, so stale contents are never emitted.
  always_ff @(posedge clk_250mhz) begin
    if (wr_en) mem[wr_idx] <= {s_axis.keep, s_axis.data};
  end

  always_ff @(posedge clk_250mhz or posedge clk_250mhz_rst) begin
    if (clk_250mhz_rst) begin
      fcnt        <= '0;
      rd          <= '0;
      seq         <= '0;
      ready_r     <= 1'b0;
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      data_r      <= '0;
      keep_r      <= '0;
      nr_recorded <= '0;
      nr_dropped  <= '0;
      busy        <= 1'b0;
    end else begin
      ready_r <= (state_next != HDR) && (state_next != DRAIN);
      busy    <= (state_next != IDLE);
      case (state)
        IDLE, FILL: if (accept) begin
          fcnt <= fcnt_inc;
          if (s_axis.last) begin
            valid_r <= 1'b1;
            data_r  <= hdr_word;
            keep_r  <= '1;
            last_r  <= 1'b0;
          end
        end
        DROP: if (accept && s_axis.last) begin
          fcnt <= '0;
          if (nr_dropped != '1) nr_dropped <= nr_dropped + 32'd1;
        end
        HDR, DRAIN: if (rec_hs) begin
          if (state == DRAIN && rd_final) begin
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            data_r      <= '0;
            keep_r      <= '0;
            fcnt        <= '0;
            seq         <= seq + SEQ_WIDTH'(1);
            nr_recorded <= nr_recorded + 64'd1;
          end else begin
            // The header handshake and each non-final data handshake preload the next buffered flit.
            rd     <= rd_idx;
            data_r <= rd_word[DATA_WIDTH-1:0];
            keep_r <= rd_word[WW-1:DATA_WIDTH];
            last_r <= rd_idx_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axis.ready     = ready_r;
  assign m_axis_rec.valid = valid_r;
  assign m_axis_rec.last  = last_r;
  assign m_axis_rec.data  = data_r;
  assign m_axis_rec.keep  = keep_r;
endmodule

// File: doc/axis_pkt_recorder.md
Name: axis_pkt_recorder

Overview:
- Store-and-forward recorder on the TCP module's outgoing network stream (m_axis_net_tx_* side of the core).
- Buffers one whole AXIS packet, then emits it as a length-prefixed record: one header flit, then the buffered flits.
- The record format is the inverse of the bench's input-packet format (flit count followed by flits), so captured traffic can be replayed or logged in hardware.
- Sits between the TCP core TX output and a logging/DMA sink.

Parameters:
- DATA_WIDTH, 512, AXIS data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, AXIS keep width.
- MAX_FLITS, 64, packet buffer depth in flits; must be a power of 2, at most 65535.
- SEQ_WIDTH, 32, width of the packet sequence number.

Ports:
- clk_250mhz  in  1  sole clock.
- clk_250mhz_rst  in  1  asynchronous, active-high reset.
- s_axis_data  in  DATA_WIDTH  input flit data.
- s_axis_keep  in  KEEP_WIDTH  input byte enables.
- s_axis_last  in  1  end of input packet.
- s_axis_valid  in  1  input valid.
- s_axis_ready  out  1  input ready.
- m_axis_rec_data  out  DATA_WIDTH  record flit data.
- m_axis_rec_keep  out  KEEP_WIDTH  record byte enables.
- m_axis_rec_last  out  1  end of record.
- m_axis_rec_valid  out  1  record valid.
- m_axis_rec_ready  in  1  record ready.
- nr_recorded  out  64  count of records fully emitted.
- nr_dropped  out  32  count of packets dropped as oversize.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; write/read pointers, flit count and seq cleared.
  - s_axis_ready=0 while reset is asserted, 1 on the first cycle after release.
  - m_axis_rec_valid=0, m_axis_rec_last=0, m_axis_rec_data=0, m_axis_rec_keep=0.
  - nr_recorded=0, nr_dropped=0, busy=0.
  - Reset mid-packet or mid-record discards everything; no counter changes.
- Transfers occur only on valid&ready at a rising clock edge. All outputs are registered.
- States:
  - IDLE: s_axis_ready=1. First accepted flit is written to buffer[0] and fcnt=1. If that flit has last=1, go to HDR; otherwise go to FILL.
  - FILL: s_axis_ready=1. Each accepted flit is written at buffer[fcnt] and fcnt increments.
    - Accepted flit with last=1: go to HDR.
    - Accepted flit with last=0 when fcnt reaches MAX_FLITS: go to DROP.
  - DROP: s_axis_ready=1. Flits are discarded until one with last=1 is accepted.
    - On that flit: nr_dropped+1 (saturates at all-ones), fcnt=0, go to IDLE.
    - seq does not increment and no record is emitted.
  - HDR: s_axis_ready=0. m_axis_rec_valid=1 is asserted the cycle after the last input flit is accepted. Header flit contents:
    - data[15:0] = fcnt.
    - data[22:16] = popcount of the last flit's keep (1..64; 64 encoded as 64).
    - data[31:23] = 0.
    - data[32+SEQ_WIDTH-1:32] = seq; all higher bits 0.
    - keep = all ones; last = 0.
    - On handshake, go to DRAIN with rd=0.
  - DRAIN: s_axis_ready=0. Emits buffer[rd] with its stored keep.
    - last=1 only when rd==fcnt-1.
    - valid stays high with data stable while ready=0.
    - On the final handshake: seq+1 (wraps mod 2^SEQ_WIDTH), nr_recorded+1, fcnt=0, go to IDLE.
    - Back-to-back throughput: one flit per cycle when m_axis_rec_ready=1.
- A packet of exactly MAX_FLITS flits whose final flit carries last=1 is recorded, not dropped.
- Minimum latency: input last accepted at cycle N gives header valid at N+1, first data flit at N+2.
- No input is accepted while in HDR or DRAIN. Upstream backpressure is the only flow control.
- Stored keep is per flit and is not checked for contiguity.
- Buffer is single-port style: a write in FILL and a read in DRAIN never coincide.

Test Plan:
- Reset, then a 1-flit packet (keep=0xFFFF_FFFF_FFFF_FFFF, data=0xAB) with sink ready=1 → header at N+1 with data[15:0]=1, data[22:16]=64, seq=0; data flit 0xAB with last=1 at N+2; nr_recorded=1.
- 3-flit packet, last keep=0x0000_0000_0000_00FF, sink ready toggling 1/0 → header fcnt=3, bytes=8, seq=1; flits are emitted in order and held stable while ready=0; last only on the 3rd flit.
- MAX_FLITS+5 flit packet → nothing emitted; nr_dropped=1, seq unchanged. The next 2-flit packet is recorded with the expected seq.
- Exactly-MAX_FLITS packet (64 flits) → recorded; header fcnt=64; 65 output flits total.
- Assert reset during DRAIN after 2 of 4 flits → outputs return to reset values immediately; counters=0; the next packet is recorded with seq=0.
- 1000 random packets of 1..64 flits with random sink stalls → output matches the reference model record-for-record; nr_recorded=1000; s_axis_ready=0 throughout every HDR/DRAIN phase.
